// File: rtl/icache_fill_pkg.sv
// Shared types and constants for the icache line-fill engine.
package icache_fill_pkg;

    // Per-entry fill lifecycle.
    typedef enum logic [2:0] {
        E_IDLE = 3'd0,
        E_REQ  = 3'd1,
        E_WAIT = 3'd2,
        E_FILL = 3'd3,
        E_DONE = 3'd4
    } entry_state_e;

    // A line arrives as four 128-bit beats, beat 0 first.
    localparam int BEATS      = 4;
    localparam int BEAT_W     = 128;
    localparam int BEAT_CNT_W = 2;
    localparam logic [BEAT_CNT_W-1:0] BEAT_FIRST = 2'd0;
    localparam logic [BEAT_CNT_W-1:0] BEAT_LAST  = 2'd3;

    // Snoop encodings of the shared cache protocol.
    localparam logic [1:0] SNOOP_NONE           = 2'd0;
    localparam logic [1:0] SNOOP_READ_SHARED    = 2'd1;
    localparam logic [1:0] SNOOP_READ_EXCLUSIVE = 2'd2;
    localparam logic [1:0] SNOOP_READ_INVALID   = 2'd3;

    // Snoops that take the line away from us and so must poison a pending fill.
    function automatic logic snoop_kills(input logic [1:0] snp);
        return (snp == SNOOP_READ_INVALID) || (snp == SNOOP_READ_EXCLUSIVE);
    endfunction

endpackage

// File: rtl/icache_fill_entry.sv
// One outstanding fill: state, line address, first-beat response and poison.
module icache_fill_entry
    import icache_fill_pkg::*;
#(
    parameter int LW = 50
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alloc,
    input  logic [LW-1:0] alloc_addr,
    input  logic          granted,
    input  logic          beat_hit,
    input  logic          beat_first,
    input  logic          beat_last,
    input  logic [2:0]    beat_resp,
    input  logic          snoop_kill,
    input  logic [LW-1:0] snoop_addr,
    output entry_state_e  state,
    output logic [LW-1:0] addr,
    output logic [2:0]    resp,
    output logic          poison
);

    // Entry FSM; poison tracks invalidating snoops for the whole life of the entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= E_IDLE;
            addr   <= '0;
            resp   <= '0;
            poison <= 1'b0;
        end else begin
            if (snoop_kill && state != E_IDLE && snoop_addr == addr)
                poison <= 1'b1;
            case (state)
                E_IDLE: if (alloc) begin
                    state  <= E_REQ;
                    addr   <= alloc_addr;
                    poison <= 1'b0;
                end
                E_REQ:  if (granted) state <= E_WAIT;
                E_WAIT: if (beat_hit && beat_first) begin
                    state <= E_FILL;
                    resp  <= beat_resp;
                end
                E_FILL: if (beat_hit && beat_last) state <= E_DONE;
                E_DONE: state <= E_IDLE;
                default: state <= E_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/icache_l1_fill.sv
// L1 icache line-fill and snoop-forwarding engine: miss tracking, fabric
// request arbitration, beat assembly into a shared line buffer, delivery.
module icache_l1_fill
    import icache_fill_pkg::*;
#(
    parameter int NPHYS            = 56,
    parameter int ACACHE_LINE_SIZE = 6,
    parameter int CACHE_LINE_SIZE  = 512,
    parameter int TRANS_ID_SIZE    = 6,
    parameter int NMISS            = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              miss_req,
    input  logic [NPHYS-ACACHE_LINE_SIZE-1:0] miss_addr,
    output logic                              miss_ack,
    output logic                              mem_req,
    output logic [NPHYS-ACACHE_LINE_SIZE-1:0] mem_addr,
    output logic [TRANS_ID_SIZE-1:0]          mem_trans,
    input  logic                              mem_ack,
    input  logic                              mem_rdata_valid,
    input  logic [127:0]                      mem_rdata,
    input  logic [TRANS_ID_SIZE-1:0]          mem_rdata_trans,
    input  logic [2:0]                        mem_rdata_resp,
    input  logic                              mem_snoop_req,
    input  logic [NPHYS-ACACHE_LINE_SIZE-1:0] mem_snoop_addr,
    input  logic [1:0]                        mem_snoop_snoop,
    output logic                              mem_snoop_ack,
    output logic                              ic_rdata_req,
    output logic [CACHE_LINE_SIZE-1:0]        ic_rdata,
    output logic [NPHYS-ACACHE_LINE_SIZE-1:0] ic_raddr,
    output logic [2:0]                        ic_rdata_resp,
    output logic                              ic_snoop_addr_req,
    output logic [NPHYS-ACACHE_LINE_SIZE-1:0] ic_snoop_addr,
    output logic [1:0]                        ic_snoop_snoop,
    input  logic                              ic_snoop_addr_ack
);

    localparam int LW = NPHYS - ACACHE_LINE_SIZE;
    localparam int IW = (NMISS > 1) ? $clog2(NMISS) : 1;

    entry_state_e             ent_state [NMISS];
    logic [NMISS-1:0][LW-1:0] ent_addr;
    logic [NMISS-1:0][2:0]    ent_resp;
    logic [NMISS-1:0]         ent_poison;
    logic [NMISS-1:0]         ent_alloc;
    logic [NMISS-1:0]         ent_grant;
    logic [NMISS-1:0]         ent_beat;

    logic          miss_hit, idle_any, req_any, done_any;
    logic [IW-1:0] idle_idx, req_low, done_idx, sel_idx;
    logic          req_hold_q;
    logic [IW-1:0] req_idx_q;

    logic [BEATS-1:0][BEAT_W-1:0] line_buf;
    logic [BEAT_CNT_W-1:0]        beat_cnt;
    logic [IW-1:0]                beat_ent;
    logic                         beat_ok, beat_acc;
    logic                         snoop_kill;

    // Scan entries: merge hit, lowest IDLE, lowest REQ, the delivering DONE entry.
    always_comb begin
        miss_hit = 1'b0;
        idle_any = 1'b0;
        idle_idx = '0;
        req_any  = 1'b0;
        req_low  = '0;
        done_any = 1'b0;
        done_idx = '0;
        for (int i = NMISS-1; i >= 0; i--) begin
            if (ent_state[i] != E_IDLE && ent_addr[i] == miss_addr) miss_hit = 1'b1;
            if (ent_state[i] == E_IDLE) begin idle_any = 1'b1; idle_idx = IW'(i); end
            if (ent_state[i] == E_REQ)  begin req_any  = 1'b1; req_low  = IW'(i); end
            if (ent_state[i] == E_DONE) begin done_any = 1'b1; done_idx = IW'(i); end
        end
    end

    assign miss_ack      = reset && miss_req && (miss_hit || idle_any);
    assign mem_snoop_ack = reset;
    assign snoop_kill    = mem_snoop_req && snoop_kills(mem_snoop_snoop);

    // A presented request stays on the same entry until the fabric takes it,
    // even if a lower-index entry becomes REQ in the meantime.
    assign sel_idx   = req_hold_q ? req_idx_q : req_low;
    assign mem_req   = req_hold_q || req_any;
    assign mem_addr  = mem_req ? ent_addr[sel_idx] : '0;
    assign mem_trans = mem_req ? TRANS_ID_SIZE'(sel_idx) : '0;

    // Remember which entry is on the request port while it waits for mem_ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_hold_q <= 1'b0;
            req_idx_q  <= '0;
        end else begin
            req_hold_q <= mem_req && !mem_ack;
            req_idx_q  <= sel_idx;
        end
    end

    // Beats are only taken for an entry expecting them; beat 0 only at counter 0.
    assign beat_ent = mem_rdata_trans[IW-1:0];
    assign beat_ok  = mem_rdata_valid &&
                      ({1'b0, mem_rdata_trans} < (TRANS_ID_SIZE+1)'(NMISS));
    assign beat_acc = beat_ok &&
                      ((ent_state[beat_ent] == E_WAIT && beat_cnt == BEAT_FIRST) ||
                       ent_state[beat_ent] == E_FILL);

    // Shared line buffer and beat counter; a write in the delivery cycle lands
    // after the icache has sampled the finished line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            line_buf <= '0;
            beat_cnt <= '0;
        end else if (beat_acc) begin
            line_buf[beat_cnt] <= mem_rdata;
            beat_cnt           <= beat_cnt + 1'b1;
        end
    end

    assign ic_rdata      = line_buf;
    assign ic_rdata_req  = done_any;
    assign ic_raddr      = done_any ? ent_addr[done_idx] : '0;
    assign ic_rdata_resp = done_any ? {ent_resp[done_idx][2:1],
                                       ent_resp[done_idx][0] & ~ent_poison[done_idx]} : '0;

    // Snoops are always accepted and forwarded to the icache one cycle later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ic_snoop_addr_req <= 1'b0;
            ic_snoop_addr     <= '0;
            ic_snoop_snoop    <= '0;
        end else begin
            ic_snoop_addr_req <= mem_snoop_req;
            ic_snoop_addr     <= mem_snoop_addr;
            ic_snoop_snoop    <= mem_snoop_snoop;
        end
    end

    // The icache never back-pressures snoops.
    always_ff @(posedge clk) begin
        if (reset && ic_snoop_addr_req) assert (ic_snoop_addr_ack);
    end

    for (genvar i = 0; i < NMISS; i++) begin : g_ent
        assign ent_alloc[i] = miss_ack && !miss_hit && idle_idx == IW'(i);
        assign ent_grant[i] = mem_req && mem_ack && sel_idx == IW'(i);
        assign ent_beat[i]  = beat_acc && beat_ent == IW'(i);

        icache_fill_entry #(.LW(LW)) u_ent (
            .clk        (clk),
            .reset      (reset),
            .alloc      (ent_alloc[i]),
            .alloc_addr (miss_addr),
            .granted    (ent_grant[i]),
            .beat_hit   (ent_beat[i]),
            .beat_first (beat_cnt == BEAT_FIRST),
            .beat_last  (beat_cnt == BEAT_LAST),
            .beat_resp  (mem_rdata_resp),
            .snoop_kill (snoop_kill),
            .snoop_addr (mem_snoop_addr),
            .state      (ent_state[i]),
            .addr       (ent_addr[i]),
            .resp       (ent_resp[i]),
            .poison     (ent_poison[i])
        );
    end

endmodule

// File: tb/tb_icache_l1_fill.sv
// Bench for icache_l1_fill: slot-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_icache_l1_fill;

    localparam int NPHYS = 56, ALS = 6, CLS = 512, TIS = 6, NMISS = 2;
    localparam int LW = NPHYS - ALS;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic miss_req = 1'b0, mem_ack = 1'b0, mem_rdata_valid = 1'b0, mem_snoop_req = 1'b0;
    logic [LW-1:0] miss_addr = '0, mem_snoop_addr = '0;
    logic [127:0] mem_rdata = '0;
    logic [TIS-1:0] mem_rdata_trans = '0;
    logic [2:0] mem_rdata_resp = '0;
    logic [1:0] mem_snoop_snoop = '0;
    logic ic_snoop_addr_ack = 1'b1;

    logic miss_ack, mem_req, mem_snoop_ack, ic_rdata_req, ic_snoop_addr_req;
    logic [LW-1:0] mem_addr, ic_raddr, ic_snoop_addr;
    logic [TIS-1:0] mem_trans;
    logic [CLS-1:0] ic_rdata;
    logic [2:0] ic_rdata_resp;
    logic [1:0] ic_snoop_snoop;

    always #5 clk = ~clk;

    icache_l1_fill #(.NPHYS(NPHYS), .ACACHE_LINE_SIZE(ALS), .CACHE_LINE_SIZE(CLS),
                     .TRANS_ID_SIZE(TIS), .NMISS(NMISS)) dut (
        .clk(clk), .reset(reset),
        .miss_req(miss_req), .miss_addr(miss_addr), .miss_ack(miss_ack),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_trans(mem_trans), .mem_ack(mem_ack),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .mem_rdata_trans(mem_rdata_trans), .mem_rdata_resp(mem_rdata_resp),
        .mem_snoop_req(mem_snoop_req), .mem_snoop_addr(mem_snoop_addr),
        .mem_snoop_snoop(mem_snoop_snoop), .mem_snoop_ack(mem_snoop_ack),
        .ic_rdata_req(ic_rdata_req), .ic_rdata(ic_rdata), .ic_raddr(ic_raddr),
        .ic_rdata_resp(ic_rdata_resp), .ic_snoop_addr_req(ic_snoop_addr_req),
        .ic_snoop_addr(ic_snoop_addr), .ic_snoop_snoop(ic_snoop_snoop),
        .ic_snoop_addr_ack(ic_snoop_addr_ack)
    );

    int checks = 0, passes = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model: slots of outstanding lines ----------------
    logic [NMISS-1:0] m_live, m_iss, m_pois, m_dlv;
    logic [LW-1:0]    m_addr [NMISS];
    logic [2:0]       m_resp [NMISS];
    logic [511:0]     m_data [NMISS];
    int               m_cnt  [NMISS];
    int               m_pres;
    logic             sq_req;
    logic [LW-1:0]    sq_addr;
    logic [1:0]       sq_snp;
    bit               chk_en = 1'b0;

    // observed deliveries / request handshakes
    int n_dlv = 0, n_hs = 0;
    logic [LW-1:0]  l_addr;
    logic [511:0]   l_data;
    logic [2:0]     l_resp;

    function automatic int req_idx();
        if (m_pres >= 0) return m_pres;
        for (int i = 0; i < NMISS; i++) if (m_live[i] && !m_iss[i]) return i;
        return -1;
    endfunction

    function automatic int dlv_idx();
        for (int i = 0; i < NMISS; i++) if (m_dlv[i]) return i;
        return -1;
    endfunction

    function automatic bit miss_hits();
        for (int i = 0; i < NMISS; i++) if (m_live[i] && m_addr[i] == miss_addr) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model
        int p, a, t;
        bit hit;
        logic [NMISS-1:0] nd;
        if (!reset) begin
            m_live = '0; m_iss = '0; m_pois = '0; m_dlv = '0; m_pres = -1;
            sq_req = 1'b0; sq_addr = '0; sq_snp = '0;
            for (int i = 0; i < NMISS; i++) m_cnt[i] = 0;
        end else begin
            hit = miss_hits();
            a = -1;
            for (int i = NMISS-1; i >= 0; i--) if (!m_live[i]) a = i;
            p = req_idx();
            if (p >= 0 && mem_ack) begin m_iss[p] = 1'b1; m_pres = -1; end
            else m_pres = p;
            if (mem_snoop_req && (mem_snoop_snoop == 2'd3 || mem_snoop_snoop == 2'd2))
                for (int i = 0; i < NMISS; i++)
                    if (m_live[i] && m_addr[i] == mem_snoop_addr) m_pois[i] = 1'b1;
            nd = '0;
            t = int'(mem_rdata_trans);
            if (mem_rdata_valid && t < NMISS) begin
                if (m_live[t] && m_iss[t] && !m_dlv[t] && m_cnt[t] < 4) begin
                    m_data[t][128*m_cnt[t] +: 128] = mem_rdata;
                    if (m_cnt[t] == 0) m_resp[t] = mem_rdata_resp;
                    m_cnt[t]++;
                    if (m_cnt[t] == 4) nd[t] = 1'b1;
                end
            end
            m_live = m_live & ~m_dlv;
            m_dlv  = nd;
            if (miss_req && !hit && a >= 0) begin
                m_live[a] = 1'b1; m_addr[a] = miss_addr; m_iss[a] = 1'b0;
                m_pois[a] = 1'b0; m_cnt[a] = 0;
            end
            sq_req = mem_snoop_req; sq_addr = mem_snoop_addr; sq_snp = mem_snoop_snoop;
        end
    end

    // Compare DUT against the model every cycle, mid-cycle.
    always @(negedge clk) begin : compare
        int d, p;
        if (chk_en) begin
            d = dlv_idx();
            p = req_idx();
            chk("miss_ack", miss_ack, reset && miss_req && (miss_hits() || !(&m_live)));
            chk("mem_snoop_ack", mem_snoop_ack, reset);
            chk("mem_req", mem_req, p >= 0);
            if (p >= 0) begin
                chk("mem_addr", mem_addr, m_addr[p]);
                chk("mem_trans", mem_trans, TIS'(p));
            end
            chk("ic_rdata_req", ic_rdata_req, d >= 0);
            if (d >= 0) begin
                chk("ic_raddr", ic_raddr, m_addr[d]);
                chk("ic_rdata", ic_rdata, m_data[d]);
                chk("ic_rdata_resp", ic_rdata_resp, {m_resp[d][2:1], m_resp[d][0] & ~m_pois[d]});
            end
            chk("ic_snoop_addr_req", ic_snoop_addr_req, sq_req);
            if (sq_req) begin
                chk("ic_snoop_addr", ic_snoop_addr, sq_addr);
                chk("ic_snoop_snoop", ic_snoop_snoop, sq_snp);
            end
        end
        if (ic_rdata_req === 1'b1) begin
            n_dlv++; l_addr = ic_raddr; l_data = ic_rdata; l_resp = ic_rdata_resp;
        end
        if (mem_req === 1'b1 && mem_ack) n_hs++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic miss(input logic [LW-1:0] a);
        miss_req = 1'b1; miss_addr = a; tick(); miss_req = 1'b0;
    endtask

    task automatic wait_req(input int tr);
        int n = 0;
        while (!(mem_req && mem_trans == TIS'(tr)) && n < 20) begin tick(); n++; end
        chk("mem_req arrives", mem_req && mem_trans == TIS'(tr), 1'b1);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    endtask

    task automatic beat(input int tr, input logic [127:0] d, input logic [2:0] rs);
        mem_rdata_valid = 1'b1; mem_rdata = d; mem_rdata_trans = TIS'(tr); mem_rdata_resp = rs;
        tick();
        mem_rdata_valid = 1'b0;
    endtask

    task automatic send_beats(input int tr, input logic [2:0] rs, input logic [127:0] base);
        for (int k = 0; k < 4; k++) beat(tr, base + 128'(k), rs);
    endtask

    localparam logic [127:0] T1B = 128'h0123456789abcdef_fedcba9876543200;
    localparam logic [127:0] T4B = 128'h5555aaaa5555aaaa_0000000000000010;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n0, h0;
        // reset
        tick(); chk_en = 1'b1; tick(); tick();
        chk("reset mem_req", mem_req, 1'b0);
        chk("reset ic_rdata_req", ic_rdata_req, 1'b0);
        chk("reset ic_snoop_addr_req", ic_snoop_addr_req, 1'b0);
        chk("reset mem_snoop_ack", mem_snoop_ack, 1'b0);
        reset = 1'b1;
        tick();

        // single fill
        miss(50'h1000);
        chk("t1 mem_req latency", mem_req, 1'b1);
        chk("t1 mem_addr", mem_addr, 50'h1000);
        wait_req(0);
        send_beats(0, 3'b001, T1B);
        chk("t1 delivery pulse", ic_rdata_req, 1'b1);
        tick(); tick();
        chk("t1 deliveries", n_dlv, 1);
        chk("t1 raddr", l_addr, 50'h1000);
        chk("t1 resp", l_resp, 3'b001);
        chk("t1 line", l_data, {128'h0123456789abcdef_fedcba9876543203,
                                128'h0123456789abcdef_fedcba9876543202,
                                128'h0123456789abcdef_fedcba9876543201,
                                128'h0123456789abcdef_fedcba9876543200});

        // full table, duplicate merge, re-presented miss
        n0 = n_dlv; h0 = n_hs;
        miss(50'h2000);
        miss_req = 1'b1; miss_addr = 50'h3000; mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        miss_addr = 50'h4000; mem_ack = 1'b1; #1;
        chk("t2 full miss_ack", miss_ack, 1'b0);
        tick(); mem_ack = 1'b0;
        miss_addr = 50'h3000; #1;
        chk("t2 dup miss_ack", miss_ack, 1'b1);
        tick();
        miss_addr = 50'h4000;
        send_beats(0, 3'b011, 128'h20);
        #1;
        chk("t2 miss_ack in delivery", miss_ack, 1'b0);
        chk("t2 delivery A", ic_rdata_req, 1'b1);
        tick();
        chk("t2 miss_ack after delivery", miss_ack, 1'b1);
        tick(); miss_req = 1'b0;
        wait_req(0);
        send_beats(1, 3'b001, 128'h30);
        send_beats(0, 3'b001, 128'h40);
        tick(); tick();
        chk("t2 deliveries", n_dlv - n0, 3);
        chk("t2 handshakes", n_hs - h0, 3);
        chk("t2 last raddr", l_addr, 50'h4000);

        // invalidating snoop on a line in FILL
        n0 = n_dlv;
        miss(50'h5000); wait_req(0);
        beat(0, 128'h50, 3'b001);
        mem_snoop_req = 1'b1; mem_snoop_addr = 50'h5000; mem_snoop_snoop = 2'd3;
        beat(0, 128'h51, 3'b001);
        mem_snoop_req = 1'b0;
        chk("t3 snoop fwd req", ic_snoop_addr_req, 1'b1);
        chk("t3 snoop fwd addr", ic_snoop_addr, 50'h5000);
        chk("t3 snoop fwd type", ic_snoop_snoop, 2'd3);
        beat(0, 128'h52, 3'b001);
        beat(0, 128'h53, 3'b001);
        chk("t3 poisoned resp", ic_rdata_resp, 3'b000);
        tick();
        chk("t3 snoop fwd gone", ic_snoop_addr_req, 1'b0);

        // shared snoop does not poison; invalidate in the delivery cycle is too late
        miss(50'h6000); wait_req(0);
        beat(0, 128'h60, 3'b101);
        mem_snoop_req = 1'b1; mem_snoop_addr = 50'h6000; mem_snoop_snoop = 2'd1;
        beat(0, 128'h61, 3'b101);
        mem_snoop_req = 1'b0;
        beat(0, 128'h62, 3'b101);
        beat(0, 128'h63, 3'b101);
        mem_snoop_req = 1'b1; mem_snoop_addr = 50'h6000; mem_snoop_snoop = 2'd3; #1;
        chk("t3 same-cycle snoop resp", ic_rdata_resp, 3'b101);
        tick(); mem_snoop_req = 1'b0;
        chk("t3 late snoop forwarded", ic_snoop_addr_req, 1'b1);
        tick();
        chk("t3 deliveries", n_dlv - n0, 2);

        // back-to-back: beat 0 of trans 1 in delivery cycle of trans 0
        n0 = n_dlv;
        miss(50'h7000); miss(50'h8000);
        wait_req(0); wait_req(1);
        send_beats(0, 3'b001, 128'h70);
        send_beats(1, 3'b001, T4B);
        tick(); tick();
        chk("t4 deliveries", n_dlv - n0, 2);
        chk("t4 last raddr", l_addr, 50'h8000);
        chk("t4 last line", l_data, {128'h5555aaaa5555aaaa_0000000000000013,
                                     128'h5555aaaa5555aaaa_0000000000000012,
                                     128'h5555aaaa5555aaaa_0000000000000011,
                                     128'h5555aaaa5555aaaa_0000000000000010});

        // reset in the middle of a fill
        n0 = n_dlv;
        miss(50'h9000); wait_req(0);
        beat(0, 128'h90, 3'b001);
        beat(0, 128'h91, 3'b001);
        reset = 1'b0;
        beat(0, 128'h92, 3'b001);
        reset = 1'b1;
        chk("t5 mem_req after reset", mem_req, 1'b0);
        chk("t5 ic_rdata_req after reset", ic_rdata_req, 1'b0);
        chk("t5 ic_rdata after reset", ic_rdata, 512'h0);
        beat(0, 128'h93, 3'b001);
        tick(); tick(); tick();
        chk("t5 no delivery", n_dlv - n0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
